// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// The control bundle and the RUN-priority evaluation live here so every user agrees on them.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned DEF_REG_ADDR_W  = 3;
    localparam int unsigned DEF_MEM_TIMEOUT = 64;
    localparam int unsigned DEF_CNT_W       = 16;

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic pr1_write;
        logic pr1_flush;
        logic pr2_write;
        logic pr2_flush;
        logic pr3_write;
        logic pr4_write;
    } hazard_ctl_t;

    localparam hazard_ctl_t CtlHold = '0;
    localparam hazard_ctl_t CtlRun  = '{
        pc_write:  1'b1,
        pr1_write: 1'b1,
        pr1_flush: 1'b0,
        pr2_write: 1'b1,
        pr2_flush: 1'b0,
        pr3_write: 1'b1,
        pr4_write: 1'b1
    };

    // Highest priority first: memory stall, taken branch, load-use bubble, free run.
    function automatic hazard_ctl_t run_eval(input logic mem_stall, input logic branch,
                                             input logic load_use);
        hazard_ctl_t ctl;
        ctl = CtlRun;
        if (mem_stall) begin
            ctl = CtlHold;
        end else if (branch) begin
            ctl.pr1_flush = 1'b1;
            ctl.pr2_flush = 1'b1;
        end else if (load_use) begin
            ctl.pc_write  = 1'b0;
            ctl.pr1_write = 1'b0;
            ctl.pr2_flush = 1'b1;
        end
        return ctl;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and the enables/flushes sent back to them.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned CNT_W      = DEF_CNT_W
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  pc_write;
    logic                  pr1_write;
    logic                  pr1_flush;
    logic                  pr2_write;
    logic                  pr2_flush;
    logic                  pr3_write;
    logic                  pr4_write;
    logic [CNT_W-1:0]      stall_count;
    logic                  err_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, pr1_write, pr1_flush, pr2_write, pr2_flush, pr3_write, pr4_write,
               stall_count, err_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, pr1_write, pr1_flush, pr2_write, pr2_flush, pr3_write, pr4_write,
               stall_count, err_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator; x0 is hardwired zero so it never creates a hazard.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// data-memory waits with a remembered branch flush, stall counter and timeout flag.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             pend_flush_q, pend_flush_d;
    logic             err_q, err_d;
    logic             load_use;
    logic             mem_stall;
    hazard_ctl_t      ctl;

    pipeline_hazard_ctrl_hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_use_rs1 (bus.id_use_rs1),
        .id_use_rs2 (bus.id_use_rs2),
        .ex_mem_read(bus.ex_mem_read),
        .ex_rd      (bus.ex_rd),
        .load_use   (load_use)
    );

    assign mem_stall = bus.mem_req && !bus.mem_ready;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        pend_flush_d = pend_flush_q;
        err_d        = err_q;
        ctl          = CtlHold;
        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    ctl = run_eval(mem_stall, bus.ex_branch_taken, load_use);
                    if (mem_stall) begin
                        state_d      = StMemWait;
                        pend_flush_d = bus.ex_branch_taken;
                    end
                end
                StMemWait: begin
                    if (mem_stall) begin
                        if (wait_cnt_q == WaitLast) begin
                            err_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WaitW'(1);
                        end
                    end else begin
                        // Resume: the frozen EX branch is replayed through the pending flag.
                        ctl          = run_eval(1'b0, bus.ex_branch_taken || pend_flush_q,
                                                load_use);
                        state_d      = StRun;
                        pend_flush_d = 1'b0;
                        wait_cnt_d   = '0;
                    end
                end
                default: state_d = StRun;
            endcase
            // Load-use also drops pc_write, so this covers both counted stall kinds.
            if (!ctl.pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            wait_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            pend_flush_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            pend_flush_q <= pend_flush_d;
            err_q        <= err_d;
        end
    end

    assign bus.pc_write    = ctl.pc_write;
    assign bus.pr1_write   = ctl.pr1_write;
    assign bus.pr1_flush   = ctl.pr1_flush;
    assign bus.pr2_write   = ctl.pr2_write;
    assign bus.pr2_flush   = ctl.pr2_flush;
    assign bus.pr3_write   = ctl.pr3_write;
    assign bus.pr4_write   = ctl.pr4_write;
    assign bus.stall_count = stall_cnt_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle RUN vectors plus
// hand-written memory-wait, timeout, saturation and reset-mid-wait sequences.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned RW = 3;
    localparam int unsigned MT = 8;
    localparam int unsigned CW = 4;

    // Control bit order: {pc_w, pr1_w, pr1_f, pr2_w, pr2_f, pr3_w, pr4_w}
    localparam logic [6:0] HOLD = 7'b0000000;
    localparam logic [6:0] RUNV = 7'b1101011;
    localparam logic [6:0] BRV  = 7'b1111111;
    localparam logic [6:0] LUV  = 7'b0001111;

    typedef struct {
        string         name;
        logic          rst;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          use1;
        logic          use2;
        logic          mrd;
        logic [RW-1:0] rd;
        logic          br;
        logic          req;
        logic          rdy;
        logic [6:0]    exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    logic exp_err = 1'b0;
    vec_t tbl[11];

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RW),
        .MEM_TIMEOUT(MT),
        .CNT_W      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic r, input int rs1, input int rs2,
                                input logic u1, input logic u2, input logic mrd, input int rd,
                                input logic br, input logic req, input logic rdy,
                                input logic [6:0] exp);
        vec_t v;
        v.name = name; v.rst = r; v.rs1 = RW'(rs1); v.rs2 = RW'(rs2);
        v.use1 = u1; v.use2 = u2; v.mrd = mrd; v.rd = RW'(rd);
        v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Drive one cycle, compare at the falling edge, then advance the count/err model.
    task automatic step(input vec_t v);
        logic [6:0] got;
        rst                 = v.rst;
        bus.id_rs1          = v.rs1;
        bus.id_rs2          = v.rs2;
        bus.id_use_rs1      = v.use1;
        bus.id_use_rs2      = v.use2;
        bus.ex_mem_read     = v.mrd;
        bus.ex_rd           = v.rd;
        bus.ex_branch_taken = v.br;
        bus.mem_req         = v.req;
        bus.mem_ready       = v.rdy;
        @(negedge clk);
        n_vec++;
        got = {bus.pc_write, bus.pr1_write, bus.pr1_flush, bus.pr2_write, bus.pr2_flush,
               bus.pr3_write, bus.pr4_write};
        chk({v.name, " ctl"}, int'(got), int'(v.exp));
        chk({v.name, " stall_count"}, int'(bus.stall_count), exp_cnt);
        chk({v.name, " err_timeout"}, int'(bus.err_timeout), int'(exp_err));
        @(posedge clk);
        #1;
        if (v.rst) begin
            exp_cnt = 0;
            exp_err = 1'b0;
        end else if (!v.exp[6] && exp_cnt < (1 << CW) - 1) begin
            exp_cnt++;
        end
    endtask

    initial begin
        tbl[0]  = mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV);
        tbl[1]  = mk("lu_rs1",      0, 3, 0, 1, 0, 1, 3, 0, 0, 0, LUV);
        tbl[2]  = mk("after_lu",    0, 3, 0, 1, 0, 0, 3, 0, 0, 0, RUNV);
        tbl[3]  = mk("rd_zero",     0, 0, 0, 1, 0, 1, 0, 0, 0, 0, RUNV);
        tbl[4]  = mk("lu_rs2",      0, 1, 5, 0, 1, 1, 5, 0, 0, 0, LUV);
        tbl[5]  = mk("rs2_unused",  0, 1, 5, 0, 0, 1, 5, 0, 0, 0, RUNV);
        tbl[6]  = mk("no_load",     0, 4, 0, 1, 0, 0, 4, 0, 0, 0, RUNV);
        tbl[7]  = mk("br_over_lu",  0, 3, 0, 1, 0, 1, 3, 1, 0, 0, BRV);
        tbl[8]  = mk("br_only",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BRV);
        tbl[9]  = mk("rs_mismatch", 0, 2, 2, 1, 1, 1, 3, 0, 0, 0, RUNV);
        tbl[10] = mk("lu_both",     0, 1, 6, 1, 1, 1, 6, 0, 0, 0, LUV);

        // Initial reset: one edge to clear state, then a reset-high cycle with busy inputs.
        rst = 1'b1;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.ex_mem_read = 0; bus.ex_rd = '0; bus.ex_branch_taken = 0;
        bus.mem_req = 0; bus.mem_ready = 0;
        @(posedge clk);
        #1;
        step(mk("in_reset", 1, 3, 0, 1, 0, 1, 3, 1, 1, 0, HOLD));

        foreach (tbl[i]) step(tbl[i]);

        // Memory wait with a branch in the first stall cycle: flush replayed on ready.
        step(mk("mw_first", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, HOLD));
        for (int i = 0; i < 3; i++) step(mk("mw_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD));
        step(mk("mw_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, BRV));
        step(mk("mw_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        chk("mw stall_count is 3+4", int'(bus.stall_count), 7);

        // mem_req dropping without ready also resumes, no flush without a branch.
        step(mk("drop_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD));
        step(mk("drop_req",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));

        // Timeout: one RUN stall cycle then nine MEM_WAIT cycles; err after the 8th.
        for (int i = 1; i <= 10; i++) begin
            step(mk("to_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD));
            if (i == 9) exp_err = 1'b1;
        end
        step(mk("to_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV));
        step(mk("to_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        chk("stall_count saturated", int'(bus.stall_count), 15);

        // Reset on the 2nd MEM_WAIT cycle drops the wait and the pending branch flush.
        step(mk("rw_first", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, HOLD));
        step(mk("rw_wait1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD));
        step(mk("rw_reset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD));
        step(mk("rw_resume", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV));
        step(mk("rw_lu", 0, 7, 0, 1, 0, 1, 7, 0, 0, 0, LUV));
        chk("post-reset stall_count", int'(bus.stall_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
